// File: rtl/logic_unit_sequencer.sv
// Self-test sequencer for the 4-lane AND/OR/XOR gate datapath: walks all 256
// {a,b} vectors under each mode, checks e_in against a reference, counts errors.
module logic_unit_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1,
    parameter int ERR_W         = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       e_in,
    output logic [3:0]       a,
    output logic [3:0]       b,
    output logic             mode_and,
    output logic             mode_or,
    output logic             mode_xor,
    output logic [3:0]       res,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, HOLD, NEXT, DONE} state_t;

    localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
    localparam logic [15:0] HOLD_LD   = 16'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);

    state_t      state;
    logic [1:0]  midx;
    logic [15:0] cnt;
    logic [3:0]  expct;

    // The a/b output registers double as the vector counter {a,b}.
    always_comb begin
        case (midx)
            2'd0:    expct = a & b;
            2'd1:    expct = a | b;
            default: expct = a ^ b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            midx     <= 2'd0;
            cnt      <= 16'd0;
            a        <= 4'd0;
            b        <= 4'd0;
            mode_and <= 1'b0;
            mode_or  <= 1'b0;
            mode_xor <= 1'b0;
            res      <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
        end else if (abort && state != IDLE) begin
            state    <= IDLE;
            a        <= 4'd0;
            b        <= 4'd0;
            mode_and <= 1'b0;
            mode_or  <= 1'b0;
            mode_xor <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        err_cnt  <= '0;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        a        <= 4'd0;
                        b        <= 4'd0;
                        midx     <= 2'd0;
                        mode_and <= 1'b1;
                        mode_or  <= 1'b0;
                        mode_xor <= 1'b0;
                        busy     <= 1'b1;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    cnt   <= SETTLE_LD;
                    state <= (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
                end
                SETTLE: begin
                    if (cnt == 16'd0) state <= CHECK;
                    else              cnt   <= cnt - 16'd1;
                end
                CHECK: begin
                    if (e_in != expct && err_cnt != '1)
                        err_cnt <= err_cnt + 1'b1;
                    res   <= e_in;
                    cnt   <= HOLD_LD;
                    state <= (HOLD_CYCLES > 0) ? HOLD : NEXT;
                end
                HOLD: begin
                    if (cnt == 16'd0) state <= NEXT;
                    else              cnt   <= cnt - 16'd1;
                end
                NEXT: begin
                    if ({a, b} != 8'hFF) begin
                        {a, b} <= {a, b} + 8'd1;
                        state  <= DRIVE;
                    end else if (midx != 2'd2) begin
                        {a, b} <= 8'd0;
                        midx   <= midx + 2'd1;
                        {mode_xor, mode_or, mode_and} <= {mode_or, mode_and, 1'b0};
                        state  <= DRIVE;
                    end else begin
                        a        <= 4'd0;
                        b        <= 4'd0;
                        mode_and <= 1'b0;
                        mode_or  <= 1'b0;
                        mode_xor <= 1'b0;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    pass  <= (err_cnt == '0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_sequencer.sv
// Bench for logic_unit_sequencer: default-timing and zero-timing instances,
// gate datapath model with injectable stuck-at faults, counts derived per vector.
module tb_logic_unit_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       start_v = 2'b00, abort_v = 2'b00;
    logic [1:0][3:0]  e_v, a_v, b_v, res_v;
    logic [1:0]       ma, mo, mx, busy_v, done_v, pass_v;
    logic [1:0][9:0]  err_v;
    logic [3:0]       fmask = 4'h0, fval = 4'h0;

    int checks = 0, failures = 0;
    int cyc = 0, t0 = 0, sel = 0;
    int bad_mode = 0;
    logic [10:0] seq[$];
    logic [10:0] last;

    logic_unit_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]), .e_in(e_v[0]),
        .a(a_v[0]), .b(b_v[0]), .mode_and(ma[0]), .mode_or(mo[0]), .mode_xor(mx[0]),
        .res(res_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err_v[0]));

    logic_unit_sequencer #(.SETTLE_CYCLES(0), .HOLD_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]), .e_in(e_v[1]),
        .a(a_v[1]), .b(b_v[1]), .mode_and(ma[1]), .mode_or(mo[1]), .mode_xor(mx[1]),
        .res(res_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err_v[1]));

    function automatic logic [3:0] gate(input logic [3:0] x, y, input logic n, o, e);
        return n ? (x & y) : o ? (x | y) : e ? (x ^ y) : 4'h0;
    endfunction

    function automatic logic [3:0] flt(input logic [3:0] v, mask, val);
        return (v & ~mask) | (val & mask);
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++)
            e_v[i] = flt(gate(a_v[i], b_v[i], ma[i], mo[i], mx[i]), fmask, fval);
    end

    always @(posedge clk) cyc++;

    // Record every distinct vector/mode presented during a run; police one-hot.
    always @(negedge clk) begin
        logic [10:0] cur;
        cur = {mx[sel], mo[sel], ma[sel], a_v[sel], b_v[sel]};
        if (busy_v[sel]) begin
            if (cur != last) begin
                seq.push_back(cur);
                last = cur;
            end
            if (!$onehot(cur[10:8])) bad_mode++;
        end else if (cur[10:8] != 3'b000) bad_mode++;
    end

    // Mismatch count for the first n vectors of the walk (mode-major, vec-minor).
    function automatic int model_err(input int n, input logic [3:0] mask, val);
        int c = 0;
        for (int i = 0; i < n; i++) begin
            int m = i / 256;
            int v = i % 256;
            int x = v / 16;
            int y = v % 16;
            int ex = (m == 0) ? (x & y) : (m == 1) ? (x | y) : (x ^ y);
            if (flt(4'(ex), mask, val) != 4'(ex)) c++;
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic kick(input int s);
        @(negedge clk);
        start_v[s] = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        start_v[s] = 1'b0;
    endtask

    task automatic wait_vec(input int s, input logic [2:0] md, input logic [7:0] v, input string tag);
        int n = 0;
        while (!(busy_v[s] && {mx[s], mo[s], ma[s]} == md && {a_v[s], b_v[s]} == v) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 20000), 1);
    endtask

    task automatic run(input int s, input logic [3:0] mask, val, input int per, input string tag);
        int n = 0, bad = 0, e;
        logic [3:0] lr;
        sel = s;
        fmask = mask;
        fval = val;
        seq.delete();
        last = '1;
        bad_mode = 0;
        kick(s);
        while (!done_v[s] && n < 768 * per + 50) begin
            @(negedge clk);
            n++;
        end
        e = model_err(768, mask, val);
        lr = flt(4'hF ^ 4'hF, mask, val);
        chk({tag, "_time"}, 32'(cyc - t0), 32'(768 * per + 1));
        chk({tag, "_done"}, 32'(done_v[s]), 1);
        chk({tag, "_err"}, 32'(err_v[s]), 32'(e));
        chk({tag, "_pass"}, 32'(pass_v[s]), 32'(e == 0));
        chk({tag, "_res"}, 32'(res_v[s]), 32'(lr));
        chk({tag, "_idle"}, {busy_v[s], ma[s], mo[s], mx[s], a_v[s], b_v[s]}, 0);
        for (int i = 0; i < 768; i++) begin
            logic [10:0] ex;
            ex = {3'(3'b001 << (i / 256)), 8'(i % 256)};
            if (i >= seq.size() || seq[i] != ex) bad++;
        end
        chk({tag, "_seqlen"}, 32'(seq.size()), 768);
        chk({tag, "_seq"}, 32'(bad), 0);
        chk({tag, "_onehot"}, 32'(bad_mode), 0);
    endtask

    initial begin
        int e;
        // T1 reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ab_res", {8'h0, a_v, b_v, res_v}, 0);
        chk("rst_ctl", {ma, mo, mx, busy_v, done_v, pass_v}, 0);
        chk("rst_err", 32'(err_v), 0);
        rst_n = 1'b1;

        // T2 golden run
        run(0, 4'h0, 4'h0, 6, "t2");

        // T3 lane 2 stuck-at-0
        run(0, 4'b0100, 4'h0, 6, "t3");
        chk("t3_err384", 32'(err_v[0]), 384);

        // T4 start while busy ignored, then abort at AND vec 0x37
        sel = 0;
        kick(0);
        wait_vec(0, 3'b001, 8'd10, "t4_reach10");
        chk("t4_t10", 32'(cyc - t0), 60);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_vec(0, 3'b001, 8'h37, "t4_reach37");
        chk("t4_t37", 32'(cyc - t0), 32'(8'h37 * 6));
        abort_v[0] = 1'b1;
        @(posedge clk);
        #1 abort_v[0] = 1'b0;
        @(negedge clk);
        chk("t4_abort_out", {busy_v[0], done_v[0], ma[0], mo[0], mx[0], a_v[0], b_v[0]}, 0);
        chk("t4_abort_err", 32'(err_v[0]), 32'(model_err(8'h37, 4'b0100, 4'h0)));

        // abort and start together in IDLE: no run
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_abort_start", {busy_v[0], ma[0], mo[0], mx[0]}, 0);

        // T5 reset mid OR pass, then full run
        fmask = 4'h0;
        kick(0);
        wait_vec(0, 3'b010, 8'h80, "t5_reach");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_rst_ab", {a_v[0], b_v[0], res_v[0]}, 0);
        chk("t5_rst_ctl", {ma[0], mo[0], mx[0], busy_v[0], done_v[0], pass_v[0], 6'(err_v[0])}, 0);
        run(0, 4'h0, 4'h0, 6, "t5");

        // T6 zero settle/hold, golden plus random stuck-at faults
        run(1, 4'h0, 4'h0, 3, "t6");
        for (int k = 0; k < 3; k++)
            run(1, 4'($urandom_range(1, 15)), 4'($urandom), 3, $sformatf("t6r%0d", k));
        e = model_err(768, fmask, fval);
        chk("t6_hold_done", {30'h0, done_v[1], pass_v[1]}, {30'h0, 1'b1, 1'(e == 0)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
